uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser_pkg.sv | 20 ++
 rtl/uart_frame_parser_frame_buffer.sv | 21 ++
 rtl/uart_frame_parser.sv | 184 ++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: FSM encoding, error causes
// and the default start-of-frame byte.
package uart_frame_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } state_e;

  localparam logic [1:0] ERR_BAD_LEN  = 2'd0;
  localparam logic [1:0] ERR_BAD_CSUM = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_frame_parser_frame_buffer.sv
// 16x8 payload store: synchronous write, registered read (one-cycle latency).
module frame_buffer (
  input  logic       clk,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [3:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [16];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: SOF, LEN, payload, XOR checksum; holds an accepted
// frame in the payload buffer until the consumer releases it.
//   state      | meaning
//   ST_IDLE    | hunting for SOF, other bytes ignored
//   ST_LEN     | waiting for the length byte
//   ST_PAYLOAD | storing payload bytes, accumulating XOR
//   ST_CHECK   | waiting for the checksum byte
//   ST_HOLD    | accepted frame held for readout until release
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter logic [7:0] SOF            = SOF_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 52080
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [4:0] payload_len,
  output logic       busy,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       release_i
);

  localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  state_e        state_q, state_d;
  logic [4:0]    len_q, len_d;
  logic [4:0]    plen_q, plen_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          busy_q, busy_d;
  logic          rd_in_range_q;
  logic          wr_en;
  logic [7:0]    buf_rdata;
  logic          in_frame;

  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    plen_d  = plen_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    tmr_d   = tmr_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    busy_d  = busy_q;
    wr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_valid && byte_in == SOF) begin
          state_d = ST_LEN;
          tmr_d   = '0;
        end
      end
      ST_LEN: begin
        if (byte_valid) begin
          tmr_d = '0;
          if (byte_in == 8'd0 || byte_in > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_LEN;
            state_d = ST_IDLE;
          end else begin
            len_d   = byte_in[4:0];
            csum_d  = byte_in;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_valid) begin
          tmr_d  = '0;
          wr_en  = 1'b1;
          csum_d = csum_q ^ byte_in;
          idx_d  = idx_q + 4'd1;
          if ({1'b0, idx_q} == len_q - 5'd1) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (byte_valid) begin
          tmr_d = '0;
          if (byte_in == csum_q) begin
            ok_d    = 1'b1;
            busy_d  = 1'b1;
            plen_d  = len_q;
            state_d = ST_HOLD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_BAD_CSUM;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // release frees the frame and lets a coincident byte start a new one
        if (release_i) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          if (byte_valid && byte_in == SOF) begin
            state_d = ST_LEN;
            tmr_d   = '0;
          end
        end else if (byte_valid) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // a byte in the expiry cycle wins because this only runs without one
    if (in_frame && !byte_valid) begin
      if (tmr_q == TMR_LAST) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        tmr_d   = '0;
        state_d = ST_IDLE;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      plen_q        <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      tmr_q         <= '0;
      ok_q          <= 1'b0;
      err_q         <= 1'b0;
      code_q        <= '0;
      busy_q        <= 1'b0;
      rd_in_range_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      plen_q        <= plen_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      tmr_q         <= tmr_d;
      ok_q          <= ok_d;
      err_q         <= err_d;
      code_q        <= code_d;
      busy_q        <= busy_d;
      rd_in_range_q <= ({1'b0, rd_addr} < plen_q);
    end
  end

  frame_buffer u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (idx_q),
    .wdata_i (byte_in),
    .raddr_i (rd_addr),
    .rdata_o (buf_rdata)
  );

  assign frame_ok    = ok_q;
  assign frame_err   = err_q;
  assign err_code    = code_q;
  assign payload_len = plen_q;
  assign busy        = busy_q;
  assign rd_data     = rd_in_range_q ? buf_rdata : 8'h00;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser with a short timeout.
module tb_uart_frame_parser;
  import uart_frame_parser_pkg::*;

  localparam int T = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [4:0] payload_len;
  logic       busy;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rel;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  uart_frame_parser #(.SOF(8'hAA), .MAX_LEN(16), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .payload_len (payload_len),
    .busy        (busy),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .release_i   (rel)
  );

  always #5 clk = ~clk;

  // pulses are counted one posedge after they become visible
  always @(posedge clk) begin
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
    if (frame_ok && frame_err) both_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
  endtask

  task automatic pulse_release();
    @(negedge clk);
    rel = 1'b1;
    @(negedge clk);
    rel = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; rd_addr = 4'd0; rel = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL reset_ok got %0b exp 0", frame_ok); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d exp 0", err_code); end
    checks++; if (payload_len !== 5'd0) begin errors++; $display("FAIL reset_payload_len got %0d exp 0", payload_len); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_good_frame();
    logic [7:0] exp_rd [4];
    exp_rd = '{8'h11, 8'h22, 8'h33, 8'h00};
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL good_early_ok got %0b exp 0", frame_ok); end
    send_byte(8'h03);
    checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL good_ok got %0b exp 1", frame_ok); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL good_err got %0b exp 0", frame_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy got %0b exp 1", busy); end
    checks++; if (payload_len !== 5'd3) begin errors++; $display("FAIL good_len got %0d exp 3", payload_len); end
    for (int i = 0; i < 4; i++) begin
      rd(4'(i));
      checks++; if (rd_data !== exp_rd[i]) begin errors++; $display("FAIL good_rd%0d got %h exp %h", i, rd_data, exp_rd[i]); end
    end
    pulse_release();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_release_busy got %0b exp 0", busy); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL good_release_state got %0d exp %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_bad_csum();
    int o0;
    o0 = ok_cnt;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL csum_err got %0b exp 1", frame_err); end
    checks++; if (err_code !== ERR_BAD_CSUM) begin errors++; $display("FAIL csum_code got %0d exp 1", err_code); end
    @(negedge clk);
    checks++; if (ok_cnt !== o0) begin errors++; $display("FAIL csum_no_ok got %0d exp %0d", ok_cnt, o0); end
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL csum_state got %0d exp %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_bad_len();
    int e0;
    e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h00);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL len0_err got %0b exp 1", frame_err); end
    checks++; if (err_code !== ERR_BAD_LEN) begin errors++; $display("FAIL len0_code got %0d exp 0", err_code); end
    send_byte(8'hAA); send_byte(8'h11);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL len17_err got %0b exp 1", frame_err); end
    checks++; if (err_code !== ERR_BAD_LEN) begin errors++; $display("FAIL len17_code got %0d exp 0", err_code); end
    @(negedge clk);
    checks++; if (err_cnt - e0 !== 2) begin errors++; $display("FAIL len_err_count got %0d exp 2", err_cnt - e0); end
    checks++; if (payload_len !== 5'd3) begin errors++; $display("FAIL len_keep_plen got %0d exp 3", payload_len); end
  endtask

  task automatic test_timeout();
    int n;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h55);
    n = 0;
    while (frame_err !== 1'b1 && n < T + 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== T) begin errors++; $display("FAIL timeout_cycles got %0d exp %0d", n, T); end
    checks++; if (err_code !== ERR_TIMEOUT) begin errors++; $display("FAIL timeout_code got %0d exp 2", err_code); end
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h24);
    checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL timeout_next_ok got %0b exp 1", frame_ok); end
    checks++; if (payload_len !== 5'd2) begin errors++; $display("FAIL timeout_next_len got %0d exp 2", payload_len); end
    pulse_release();
  endtask

  task automatic test_coincide();
    int e0;
    send_byte(8'hAA);
    repeat (T - 2) @(negedge clk);
    e0 = err_cnt;
    send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
    checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL coincide_ok got %0b exp 1", frame_ok); end
    @(negedge clk);
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL coincide_no_err got %0d exp %0d", err_cnt, e0); end
  endtask

  task automatic test_overrun();
    int e0;
    e0 = err_cnt;
    send_byte(8'h77);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL overrun_err got %0b exp 1", frame_err); end
    checks++; if (err_code !== ERR_OVERRUN) begin errors++; $display("FAIL overrun_code got %0d exp 3", err_code); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy got %0b exp 1", busy); end
    checks++; if (dut.state_q !== ST_HOLD) begin errors++; $display("FAIL overrun_state got %0d exp %0d", dut.state_q, ST_HOLD); end
    rd(4'd0);
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL overrun_buf got %h exp 5a", rd_data); end
    @(negedge clk);
    rel = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA;
    @(negedge clk);
    rel = 1'b0; byte_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL relsof_busy got %0b exp 0", busy); end
    checks++; if (dut.state_q !== ST_LEN) begin errors++; $display("FAIL relsof_state got %0d exp %0d", dut.state_q, ST_LEN); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL relsof_err got %0b exp 0", frame_err); end
    @(negedge clk);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL overrun_err_count got %0d exp 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    int e0;
    send_byte(8'h02); send_byte(8'h99);
    e0 = err_cnt;
    @(negedge clk);
    reset = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA;
    @(negedge clk);
    reset = 1'b0; byte_valid = 1'b0;
    checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rmid_state got %0d exp %0d", dut.state_q, ST_IDLE); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL rmid_code got %0d exp 0", err_code); end
    checks++; if (payload_len !== 5'd0) begin errors++; $display("FAIL rmid_len got %0d exp 0", payload_len); end
    checks++; if (busy !== 1'b0 || frame_ok !== 1'b0 || rd_data !== 8'h00) begin
      errors++; $display("FAIL rmid_outs got busy=%0b ok=%0b rd=%h exp 0 0 00", busy, frame_ok, rd_data);
    end
    @(negedge clk);
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL rmid_no_err got %0d exp %0d", err_cnt, e0); end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
    checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL rmid_next_ok got %0b exp 1", frame_ok); end
    checks++; if (payload_len !== 5'd1) begin errors++; $display("FAIL rmid_next_len got %0d exp 1", payload_len); end
    rd(4'd0);
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL rmid_rd0 got %h exp 5a", rd_data); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_timeout();
    test_coincide();
    test_overrun();
    test_reset_mid();
    @(negedge clk);
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL ok_err_overlap got %0d exp 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
